// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int BEAT_W = 2;
    localparam int WAIT_W = 3;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_assembler.sv
// Collects the four little-endian byte beats of an instruction into a 32-bit word.
// Latency: instr updates on the edge that captures beat 3.
// Backpressure: none; the sequencer only pulses cap_en when a byte is valid.
module instr_assembler
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [BEAT_W-1:0] beat,
    input  logic [7:0]        byte_in,
    output logic [31:0]       instr
);

    logic [23:0] shadow_q, shadow_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  lane_we;

    // Decode the beat into a shadow-lane write enable; the final beat skips the
    // shadow and transfers the whole word into instr in one step.
    always_comb begin
        lane_we  = '0;
        shadow_d = shadow_q;
        instr_d  = instr_q;
        if (cap_en) begin
            case (beat)
                2'd0:    lane_we[0] = 1'b1;
                2'd1:    lane_we[1] = 1'b1;
                2'd2:    lane_we[2] = 1'b1;
                default: instr_d    = {byte_in, shadow_q};
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            if (lane_we[i]) begin
                shadow_d[i*8 +: 8] = byte_in;
            end
        end
    end

    // Shadow lanes and the presented instruction; reset discards partial bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            instr_q  <= INSTR_NOP;
        end else begin
            shadow_q <= shadow_d;
            instr_q  <= instr_d;
        end
    end

    assign instr = instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches each instruction as four byte beats and strobes execute once per instruction.
// Latency: 4*(WAIT_STATES+1) fetch cycles plus one EXEC cycle per instruction.
// Backpressure: none from the ROM; halt/resume from branch/CSR logic stalls fetch in HALT.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned IMEM_AW     = 17
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_oe_n,
    input  logic [7:0]         imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr,
    output logic               exec_n,
    input  logic               pc_load_n,
    input  logic [31:0]        pc_target,
    input  logic               halt_n,
    input  logic               resume_n,
    output logic               fault_n
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_STATES[WAIT_W-1:0];

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]         pc_q, pc_d;
    logic [IMEM_AW-1:0]  addr_q, addr_d;
    logic                exec_n_q, exec_n_d;
    logic                oe_n_q, oe_n_d;
    logic                fault_n_q, fault_n_d;
    logic                cap_en;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state, counters, PC update and registered-output precompute.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_cnt_d = wait_cnt_q;
        pc_d       = pc_q;
        fault_n_d  = fault_n_q;
        cap_en     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    cap_en     = 1'b1;
                    wait_cnt_d = '0;
                    beat_d     = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_EXEC: begin
                // A misaligned redirect freezes the PC so the faulting
                // instruction's address stays visible while halted.
                if (!pc_load_n && (pc_target[1:0] != 2'b00)) begin
                    fault_n_d = 1'b0;
                    state_d   = ST_HALT;
                end else begin
                    pc_d       = !pc_load_n ? pc_target : pc_plus4;
                    state_d    = !halt_n ? ST_HALT : ST_FETCH;
                    beat_d     = '0;
                    wait_cnt_d = '0;
                end
            end
            ST_HALT: begin
                if (!resume_n) begin
                    state_d    = ST_FETCH;
                    beat_d     = '0;
                    wait_cnt_d = '0;
                    fault_n_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ST_FETCH;
                beat_d     = '0;
                wait_cnt_d = '0;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        exec_n_d = (state_d != ST_EXEC);
        oe_n_d   = (state_d != ST_FETCH);
        addr_d   = (state_d == ST_FETCH) ? {pc_d[IMEM_AW-1:2], beat_d} : addr_q;
    end

    // State, counters, PC and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            beat_q     <= '0;
            wait_cnt_q <= '0;
            pc_q       <= RESET_PC;
            addr_q     <= {RESET_PC[IMEM_AW-1:2], 2'b00};
            exec_n_q   <= 1'b1;
            oe_n_q     <= 1'b1;
            fault_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_cnt_q <= wait_cnt_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            exec_n_q   <= exec_n_d;
            oe_n_q     <= oe_n_d;
            fault_n_q  <= fault_n_d;
        end
    end

    instr_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .cap_en  (cap_en),
        .beat    (beat_q),
        .byte_in (imem_data),
        .instr   (instr)
    );

    assign pc        = pc_q;
    assign imem_addr = addr_q;
    assign imem_oe_n = oe_n_q;
    assign exec_n    = exec_n_q;
    assign fault_n   = fault_n_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: WAIT_STATES=1 instance for most scenarios,
// WAIT_STATES=0 instance for PC wrap and instruction period.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [0:131071];

    // WAIT_STATES = 1 instance
    logic        rst, imem_oe_n, exec_n, pc_load_n, halt_n, resume_n, fault_n;
    logic [16:0] imem_addr;
    logic [7:0]  imem_data;
    logic [31:0] pc, pc_plus4, instr, pc_target;

    // WAIT_STATES = 0 instance
    logic        rst0, imem_oe_n0, exec_n0, pc_load_n0, halt_n0, resume_n0, fault_n0;
    logic [16:0] imem_addr0;
    logic [7:0]  imem_data0;
    logic [31:0] pc0, pc_plus4_0, instr0, pc_target0;

    assign imem_data  = rom[imem_addr];
    assign imem_data0 = rom[imem_addr0];

    fetch_sequencer #(.RESET_PC(32'h0), .WAIT_STATES(1), .IMEM_AW(17)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_oe_n(imem_oe_n),
        .imem_data(imem_data), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
        .exec_n(exec_n), .pc_load_n(pc_load_n), .pc_target(pc_target),
        .halt_n(halt_n), .resume_n(resume_n), .fault_n(fault_n)
    );

    fetch_sequencer #(.RESET_PC(32'h0), .WAIT_STATES(0), .IMEM_AW(17)) dut0 (
        .clk(clk), .rst(rst0), .imem_addr(imem_addr0), .imem_oe_n(imem_oe_n0),
        .imem_data(imem_data0), .pc(pc0), .pc_plus4(pc_plus4_0), .instr(instr0),
        .exec_n(exec_n0), .pc_load_n(pc_load_n0), .pc_target(pc_target0),
        .halt_n(halt_n0), .resume_n(resume_n0), .fault_n(fault_n0)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t sb0[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [16:0] b;
        b = {a[16:2], 2'b00};
        return {rom[b + 17'd3], rom[b + 17'd2], rom[b + 17'd1], rom[b]};
    endfunction

    // Waits (bounded) for the execute strobe of the selected instance.
    task automatic wait_exec(input bit sel0, input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if ((sel0 ? exec_n0 : exec_n) === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int cyc; bit ok; exp_t e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pc !== 32'h0 || instr !== NOP || exec_n !== 1'b1 || imem_oe_n !== 1'b1 || fault_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: pc=%h instr=%h exec_n=%b oe_n=%b fault_n=%b, required 0/%h/1/1/1",
                     pc, instr, exec_n, imem_oe_n, fault_n, NOP);
        end
        rst = 1'b0;
        sb.push_back('{pc: 32'h0, instr: 32'h0010_0513});
        @(negedge clk);
        n_cmp++;
        if (imem_oe_n !== 1'b0 || imem_addr !== 17'h0) begin
            n_err++;
            $display("FAIL fetch_start: oe_n=%b addr=%h, required 0/00000", imem_oe_n, imem_addr);
        end
        wait_exec(1'b0, 20, cyc, ok);
        cyc++;
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 8) begin
            n_err++;
            $display("FAIL first_latency: strobe=%b after %0d cycles, required strobe after 8", ok, cyc);
        end
        n_cmp++;
        if (pc !== e.pc || instr !== e.instr || imem_oe_n !== 1'b1 || pc_plus4 !== e.pc + 32'd4) begin
            n_err++;
            $display("FAIL first_exec: pc=%h instr=%h oe_n=%b pc_plus4=%h, required %h/%h/1/%h",
                     pc, instr, imem_oe_n, pc_plus4, e.pc, e.instr, e.pc + 32'd4);
        end
        @(negedge clk);
        n_cmp++;
        if (exec_n !== 1'b1 || pc !== 32'h4) begin
            n_err++;
            $display("FAIL first_pc_step: exec_n=%b pc=%h, required 1/00000004", exec_n, pc);
        end
    endtask

    task automatic test_redirect;
        int cyc; bit ok; exp_t e;
        logic [16:0] addrs[$];
        sb.push_back('{pc: 32'h4, instr: rom_word(32'h4)});
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL seq_exec: strobe=%b pc=%h instr=%h, required 1/%h/%h", ok, pc, instr, e.pc, e.instr);
        end
        pc_load_n = 1'b0;
        pc_target = 32'h0000_0100;
        sb.push_back('{pc: 32'h100, instr: rom_word(32'h100)});
        @(negedge clk);
        pc_load_n = 1'b1;
        n_cmp++;
        if (pc !== 32'h100) begin
            n_err++;
            $display("FAIL redirect_pc: pc=%h, required 00000100", pc);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (exec_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            if (imem_oe_n === 1'b0 && (addrs.size() == 0 || addrs[$] != imem_addr))
                addrs.push_back(imem_addr);
            @(negedge clk);
        end
        n_cmp++;
        if (addrs.size() != 4 || addrs[0] !== 17'h100 || addrs[1] !== 17'h101 ||
            addrs[2] !== 17'h102 || addrs[3] !== 17'h103) begin
            n_err++;
            $display("FAIL redirect_addr_seq: %0d addresses first=%h, required 100,101,102,103",
                     addrs.size(), (addrs.size() > 0) ? addrs[0] : 17'h0);
        end
        e = sb.pop_front();
        n_cmp++;
        if (!ok || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL redirect_exec: strobe=%b pc=%h instr=%h, required 1/%h/%h", ok, pc, instr, e.pc, e.instr);
        end
    endtask

    task automatic test_fault;
        int cyc; bit ok; exp_t e; int busy;
        pc_load_n = 1'b0;
        pc_target = 32'h0000_0102;
        @(negedge clk);
        pc_load_n = 1'b1;
        n_cmp++;
        if (fault_n !== 1'b0 || pc !== 32'h100 || imem_oe_n !== 1'b1) begin
            n_err++;
            $display("FAIL fault_capture: fault_n=%b pc=%h oe_n=%b, required 0/00000100/1", fault_n, pc, imem_oe_n);
        end
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_oe_n === 1'b0 || exec_n === 1'b0) busy++;
        end
        n_cmp++;
        if (busy != 0) begin
            n_err++;
            $display("FAIL fault_halted: %0d active cycles, required 0", busy);
        end
        resume_n = 1'b0;
        sb.push_back('{pc: 32'h100, instr: rom_word(32'h100)});
        @(negedge clk);
        resume_n = 1'b1;
        n_cmp++;
        if (fault_n !== 1'b1 || imem_oe_n !== 1'b0) begin
            n_err++;
            $display("FAIL fault_resume: fault_n=%b oe_n=%b, required 1/0", fault_n, imem_oe_n);
        end
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL fault_refetch: strobe=%b pc=%h instr=%h, required 1/%h/%h", ok, pc, instr, e.pc, e.instr);
        end
    endtask

    task automatic test_halt;
        int cyc; bit ok; exp_t e; int busy;
        pc_load_n = 1'b0;
        pc_target = 32'h0000_0040;
        sb.push_back('{pc: 32'h40, instr: rom_word(32'h40)});
        @(negedge clk);
        pc_load_n = 1'b1;
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL halt_setup_exec: strobe=%b pc=%h instr=%h, required 1/%h/%h", ok, pc, instr, e.pc, e.instr);
        end
        halt_n = 1'b0;
        @(negedge clk);
        halt_n = 1'b1;
        n_cmp++;
        if (pc !== 32'h44 || imem_oe_n !== 1'b1 || fault_n !== 1'b1) begin
            n_err++;
            $display("FAIL halt_enter: pc=%h oe_n=%b fault_n=%b, required 00000044/1/1", pc, imem_oe_n, fault_n);
        end
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (exec_n === 1'b0 || imem_oe_n === 1'b0) busy++;
        end
        n_cmp++;
        if (busy != 0) begin
            n_err++;
            $display("FAIL halt_hold: %0d active cycles, required 0", busy);
        end
        resume_n = 1'b0;
        sb.push_back('{pc: 32'h44, instr: rom_word(32'h44)});
        @(negedge clk);
        resume_n = 1'b1;
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL halt_resume_exec: strobe=%b pc=%h instr=%h, required 1/%h/%h", ok, pc, instr, e.pc, e.instr);
        end
    endtask

    task automatic test_reset_mid_fetch;
        int cyc; bit ok; exp_t e;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_oe_n === 1'b0 && imem_addr[1:0] == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL midreset_find_beat2: beat 2 seen=%b, required 1", ok);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || instr !== NOP || exec_n !== 1'b1 || imem_oe_n !== 1'b1 || imem_addr !== 17'h0) begin
            n_err++;
            $display("FAIL midreset_state: pc=%h instr=%h exec_n=%b oe_n=%b addr=%h, required 0/%h/1/1/0",
                     pc, instr, exec_n, imem_oe_n, imem_addr, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{pc: 32'h0, instr: rom_word(32'h0)});
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 8 || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL midreset_refetch: strobe=%b cyc=%0d pc=%h instr=%h, required 1/8/%h/%h",
                     ok, cyc, pc, instr, e.pc, e.instr);
        end
        // Back-to-back sequential instruction: period 4*(1+1)+1.
        sb.push_back('{pc: 32'h4, instr: rom_word(32'h4)});
        wait_exec(1'b0, 20, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 9 || pc !== e.pc || instr !== e.instr) begin
            n_err++;
            $display("FAIL back_to_back: strobe=%b cyc=%0d pc=%h instr=%h, required 1/9/%h/%h",
                     ok, cyc, pc, instr, e.pc, e.instr);
        end
    endtask

    task automatic test_wrap_period;
        int cyc; bit ok; exp_t e;
        @(negedge clk);
        rst0 = 1'b0;
        sb0.push_back('{pc: 32'h0, instr: 32'h0010_0513});
        wait_exec(1'b1, 20, cyc, ok);
        e = sb0.pop_front();
        n_cmp++;
        if (!ok || cyc != 4 || pc0 !== e.pc || instr0 !== e.instr) begin
            n_err++;
            $display("FAIL ws0_first: strobe=%b cyc=%0d pc=%h instr=%h, required 1/4/%h/%h",
                     ok, cyc, pc0, instr0, e.pc, e.instr);
        end
        pc_load_n0 = 1'b0;
        pc_target0 = 32'hFFFF_FFFC;
        sb0.push_back('{pc: 32'hFFFF_FFFC, instr: rom_word(32'hFFFF_FFFC)});
        @(negedge clk);
        pc_load_n0 = 1'b1;
        wait_exec(1'b1, 20, cyc, ok);
        e = sb0.pop_front();
        n_cmp++;
        if (!ok || cyc != 4 || pc0 !== e.pc || instr0 !== e.instr || pc_plus4_0 !== 32'h0) begin
            n_err++;
            $display("FAIL ws0_top_exec: strobe=%b cyc=%0d pc=%h instr=%h pc_plus4=%h, required 1/4/%h/%h/0",
                     ok, cyc, pc0, instr0, pc_plus4_0, e.pc, e.instr);
        end
        sb0.push_back('{pc: 32'h0, instr: rom_word(32'h0)});
        wait_exec(1'b1, 20, cyc, ok);
        e = sb0.pop_front();
        n_cmp++;
        if (!ok || cyc != 5 || pc0 !== e.pc || instr0 !== e.instr) begin
            n_err++;
            $display("FAIL ws0_wrap: strobe=%b cyc=%0d pc=%h instr=%h, required 1/5/%h/%h",
                     ok, cyc, pc0, instr0, e.pc, e.instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) rom[i] = 8'((i * 37) + (i >> 8) + 11);
        rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h10; rom[3] = 8'h00;
        rst = 1'b1; pc_load_n = 1'b1; pc_target = '0; halt_n = 1'b1; resume_n = 1'b1;
        rst0 = 1'b1; pc_load_n0 = 1'b1; pc_target0 = '0; halt_n0 = 1'b1; resume_n0 = 1'b1;
        test_reset();
        test_redirect();
        test_fault();
        test_halt();
        test_reset_mid_fetch();
        test_wrap_period();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
